// File: rtl/seq_chunk_adder_if.sv
// seq_chunk_adder_if
// Bundles the operand (input) and result (output) handshakes of
// seq_chunk_adder.
//   in_valid/in_ready/a/b/cin[/sub] : operand channel, producer -> adder
//   out_valid/out_ready/sum/cout/overflow : result channel, adder -> consumer
// Handshake rule, both channels: a transfer happens on a rising clk edge
// where valid && ready are both 1. The sender holds valid and its payload
// until that edge. ready may depend on the receiver's state only, never on
// the sender's valid.
// Optional feature: defining SEQ_CHUNK_ADDER_SUB_EN adds the sub signal.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, overflow);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, overflow);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, overflow);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, overflow);
`endif
endinterface

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder
// Multi-cycle adder: adds two WIDTH-bit operands CHUNK bits per clock. A
// single registered carry ripples from one chunk to the next. One result
// takes NCHUNK = WIDTH/CHUNK cycles in RUN.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : seq_chunk_adder_if.slave (operand and result handshakes)
//   state_o  : current FSM state (IDLE=0, RUN=1, DONE=2), debug visibility
// Optional feature: define SEQ_CHUNK_ADDER_SUB_EN to add the bus.sub input.
// With sub=1 the block computes a-b as a + ~b + 1, and cin is ignored.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_chunk_adder_if.slave      bus,
  output logic [1:0]            state_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;

  logic [WIDTH-1:0]   b_eff;
  logic               c_init;
  logic [CHUNK:0]     chunk_sum;
  logic [WIDTH-1:0]   acc_next;
  logic               in_ready_c;
  logic               out_valid_c;

  // Operand B and the initial carry, as seen at the accept edge.
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  assign b_eff  = bus.sub ? ~bus.b : bus.b;
  assign c_init = bus.sub ? 1'b1   : bus.cin;
`else
  assign b_eff  = bus.b;
  assign c_init = bus.cin;
`endif

  // One chunk of the addition. The chunk's sum bits enter the accumulator
  // at the top. After NCHUNK shifts the first chunk has reached bit 0.
  // A shift by CHUNK avoids a zero-width slice when CHUNK == WIDTH.
  assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};
  assign acc_next  = (acc_q >> CHUNK)
                   | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = b_eff;
          carry_d = c_init;
          cnt_d   = '0;
          // Sign bits are kept separately because a_q and b_q shift away.
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = b_eff[WIDTH-1];
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        acc_d   = acc_next;
        carry_d = chunk_sum[CHUNK];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NCHUNK - 1)) begin
          sum_d   = acc_next;
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = (a_msb_q == b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        // in_ready stays low on the handshake cycle itself. It rises only
        // once the FSM is back in IDLE.
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign state_o       = state_q;

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
Parametrised multi-cycle adder that adds two WIDTH-bit operands CHUNK bits per clock. A single registered carry ripples between chunks. It is the sequential successor to the team's fixed-width combinational ripple-carry adder. Operands arrive and results leave over valid/ready handshakes, so the block can sit between pipelined datapath stages and trade area for latency.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.
(derived) NCHUNK = WIDTH/CHUNK, number of cycles per addition; counter width = max(1, $clog2(NCHUNK)).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand transfer request.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  registered result.
cout  output  1  carry out of bit WIDTH-1.
overflow  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, internal shift registers, carry and counter = 0.
- Reset mid-operation: any in-flight addition is discarded with no partial output. The first operation after reset is unaffected.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b; carry<=cin; count<=0; go to RUN.
  - Operands are sampled only on this edge.
- RUN:
  - in_ready=0.
  - Each cycle: {c, s} = a_reg[CHUNK-1:0] + b_reg[CHUNK-1:0] + carry.
  - s is shifted into the top of the accumulator (accumulator shifts right by CHUNK); a_reg and b_reg shift right by CHUNK; carry<=c; count++.
  - On the cycle where count==NCHUNK-1:
    - sum <= final accumulator value.
    - cout <= c.
    - overflow <= (a[WIDTH-1]==b_eff[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]). The MSBs of a and b_eff are captured at accept.
    - Go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, cout and overflow are held stable for as long as out_ready=0.
  - On out_valid && out_ready: go to IDLE; out_valid deasserts on the next cycle.
  - A new operand is not accepted in the same cycle as the output handshake. in_ready rises one cycle later.
- Latency: operands accepted at edge k give out_valid high after edge k+NCHUNK. NCHUNK=1 gives 1-cycle latency. Throughput is one result per NCHUNK+2 cycles with out_ready held high.
- Output hold: sum, cout and overflow keep the last result until the next completion overwrites them. They are meaningful only while out_valid=1.
- Width rules:
  - All arithmetic is modulo 2^WIDTH; cout is the carry out of the MSB.
  - No sign extension is applied; overflow treats the operands as signed.
- in_valid during RUN or DONE is ignored; the operands are not captured.

Optional Feature:
Macro SEQ_CHUNK_ADDER_SUB_EN.
- Defined:
  - Adds port sub (input, 1 bit), sampled together with a and b at accept.
  - When sub=1: b_eff = ~b and the initial carry = 1, giving a-b; cin is ignored.
  - When sub=0: behaviour is identical to the add-only build.
  - cout=1 means no borrow.
- Undefined: there is no sub port, b_eff = b, and the block only adds.

Test Plan:
All scenarios use WIDTH=16, CHUNK=4 unless stated.
1. Reset: hold rst_n=0 for 3 cycles -> in_ready=1, out_valid=0, sum=0x0000, cout=0, overflow=0.
2. Basic add: a=0x1234, b=0x4321, cin=0, out_ready=1 -> out_valid rises exactly 4 cycles after accept; sum=0x5555, cout=0, overflow=0.
3. Full carry ripple and signed overflow:
   - a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0.
   - a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1.
4. Backpressure: out_ready=0 for 5 cycles after out_valid while in_valid pulses with a new operand -> out_valid stays 1; sum, cout and overflow are stable; in_ready=0; the pulsed operand is not captured. Then raise out_ready -> out_valid drops the next cycle and in_ready rises one cycle later.
5. Reset mid-RUN: accept a=0x00FF, b=0x0001, then drop rst_n after 2 RUN cycles -> all outputs return to reset values immediately. The next op a=0x0003, b=0x0004, cin=1 gives sum=0x0008.
6. Parameter sweep and subtract:
   - CHUNK=1 and CHUNK=16 with random operands -> matches a+b+cin; latency is 16 and 1 respectively.
   - With SEQ_CHUNK_ADDER_SUB_EN defined: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, overflow=0.
